// File: rtl/booth_enc_stage.sv
// rtl/booth_enc_stage.sv - radix-4 Booth encode stage with 2-entry skid buffer
module booth_enc_stage #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [33:0]      out_multiplier1,
    output logic [16:0]      out_set0,
    output logic [16:0]      out_x2,
    output logic [16:0]      out_inv,
    output logic [1:0]       out_op,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [33:0]      mult1;
        logic [16:0]      set0;
        logic [16:0]      x2;
        logic [16:0]      inv;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t     enc;
    entry_t     main_q;
    entry_t     skid_q;
    logic       main_valid;
    logic       skid_valid;
    logic       s1;
    logic       s2;
    logic [34:0] b_ext;
    logic       accept;
    logic       drain;

    // b_ext carries the implicit B[-1]=0 in bit 0 so digit i reads b_ext[2i+2:2i]
    always_comb begin
        enc   = '0;
        s1    = (in_op != 2'b11);
        s2    = !in_op[1];
        b_ext = {{2{s2 & in_rs2[31]}}, in_rs2, 1'b0};
        enc.mult1 = {{2{s1 & in_rs1[31]}}, in_rs1};
        enc.op    = in_op;
        enc.tag   = in_tag;
        for (int i = 0; i < 17; i++) begin
            case (b_ext[2*i+2 -: 3])
                3'b000, 3'b111: begin
                    enc.set0[i] = 1'b1;
                end
                3'b001, 3'b010: begin
                end
                3'b011: begin
                    enc.x2[i] = 1'b1;
                end
                3'b100: begin
                    enc.x2[i]  = 1'b1;
                    enc.inv[i] = 1'b1;
                end
                default: begin
                    enc.inv[i] = 1'b1;
                end
            endcase
        end
    end

    assign in_ready = !skid_valid;
    assign accept   = in_valid & in_ready;
    assign drain    = main_valid & out_ready;

    // skid holds the younger entry; it only fills while main is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (drain) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end
        end else if (!main_valid || drain) begin
            main_valid <= accept;
            if (accept) begin
                main_q <= enc;
            end
        end else if (accept) begin
            skid_q     <= enc;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid       = main_valid;
    assign out_multiplier1 = main_q.mult1;
    assign out_set0        = main_q.set0;
    assign out_x2          = main_q.x2;
    assign out_inv         = main_q.inv;
    assign out_op          = main_q.op;
    assign out_tag         = main_q.tag;

endmodule

// File: tb/tb_booth_enc_stage.sv
// tb/tb_booth_enc_stage.sv - randomized scoreboard bench for booth_enc_stage
module tb_booth_enc_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [33:0] out_multiplier1;
    logic [16:0] out_set0;
    logic [16:0] out_x2;
    logic [16:0] out_inv;
    logic [1:0]  out_op;
    logic [3:0]  out_tag;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [33:0] mult1;
        logic [16:0] set0;
        logic [16:0] x2;
        logic [16:0] inv;
        logic [1:0]  op;
        logic [3:0]  tag;
        longint      bval;
    } item_t;

    item_t q[$];

    booth_enc_stage #(.TAG_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_multiplier1(out_multiplier1), .out_set0(out_set0),
        .out_x2(out_x2), .out_inv(out_inv), .out_op(out_op), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    function void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endfunction

    // Reference: digit value d_i = -2*B[2i+1] + B[2i] + B[2i-1], operands as plain integers
    function item_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        item_t  it;
        longint av, bv, d;
        longint bit_hi, bit_mid, bit_lo;
        logic [63:0] av_bits;
        av = (op != 2'd3) ? longint'($signed(a)) : longint'(a);
        bv = (op <= 2'd1) ? longint'($signed(b)) : longint'(b);
        av_bits = av;
        it.mult1 = av_bits[33:0];
        it.op = op;
        it.tag = tag;
        it.bval = bv;
        it.set0 = '0;
        it.x2 = '0;
        it.inv = '0;
        for (int i = 0; i < 17; i++) begin
            bit_hi  = (bv >>> (2*i+1)) & 1;
            bit_mid = (bv >>> (2*i)) & 1;
            bit_lo  = (i == 0) ? 0 : ((bv >>> (2*i-1)) & 1);
            d = -2*bit_hi + bit_mid + bit_lo;
            it.set0[i] = (d == 0);
            it.x2[i]   = (d == 2 || d == -2);
            it.inv[i]  = (d < 0);
        end
        return it;
    endfunction

    function longint digit_sum(input logic [16:0] s0, input logic [16:0] x2, input logic [16:0] iv);
        longint sum, mag;
        sum = 0;
        for (int i = 0; i < 17; i++) begin
            mag = s0[i] ? 0 : (x2[i] ? 2 : 1);
            sum += (iv[i] ? -mag : mag) * (longint'(1) << (2*i));
        end
        return sum;
    endfunction

    // Scoreboard: queue holds the entries the stage must contain, oldest first
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            chk("in_ready_vs_occupancy", in_ready, (q.size() < 2));
            chk("out_valid_vs_occupancy", out_valid, (q.size() > 0));
            if (out_valid && q.size() > 0) begin
                chk("mult1", out_multiplier1, q[0].mult1);
                chk("set0", out_set0, q[0].set0);
                chk("x2", out_x2, q[0].x2);
                chk("inv", out_inv, q[0].inv);
                chk("op", out_op, q[0].op);
                chk("tag", out_tag, q[0].tag);
                chk("digit_sum", digit_sum(out_set0, out_x2, out_inv), q[0].bval);
            end
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
                if (in_valid && in_ready) q.push_back(model(in_op, in_rs1, in_rs2, in_tag));
            end
        end
    end

    task automatic drive_rand(input logic [3:0] tag);
        int sel;
        in_op  = 2'($urandom);
        in_rs1 = $urandom;
        sel    = $urandom_range(0, 7);
        case (sel)
            0: in_rs2 = 32'hFFFFFFFF;
            1: in_rs2 = 32'h80000000;
            2: in_rs2 = 32'h0;
            3: in_rs2 = 32'h7FFFFFFF;
            default: in_rs2 = $urandom;
        endcase
        in_tag = tag;
    endtask

    task automatic send_one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag;
        out_ready = 1'b1; flush = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        item_t m;
        int sent, drained, cyc;
        logic acc;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;

        // Model pinned against hand-computed encodings
        m = model(2'd0, 32'd3, 32'd5, 4'd0);
        chk("model_mul5_set0", m.set0, 17'h1FFFC);
        m = model(2'd1, 32'd0, 32'hFFFFFFFF, 4'd0);
        chk("model_mulh_m1_set0", m.set0, 17'h1FFFE);
        m = model(2'd3, 32'h80000000, 32'hFFFFFFFF, 4'd0);
        chk("model_mulhu_set0", m.set0, 17'h0FFFE);
        chk("model_mulhu_mult1", m.mult1, 34'h080000000);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_mult1", out_multiplier1, 0);
        chk("reset_set0", out_set0, 0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", in_ready, 1);
        idle(2);

        send_one(2'd0, 32'd3, 32'd5, 4'd1);
        chk("t1_valid", out_valid, 1);
        chk("t1_set0", out_set0, 17'h1FFFC);
        chk("t1_x2", out_x2, 17'h0);
        chk("t1_inv", out_inv, 17'h0);
        chk("t1_mult1", out_multiplier1, 34'h3);

        send_one(2'd1, 32'd0, 32'hFFFFFFFF, 4'd2);
        chk("t2_mulh_set0", out_set0, 17'h1FFFE);
        chk("t2_mulh_inv", out_inv, 17'h00001);
        chk("t2_mulh_x2", out_x2, 17'h0);
        send_one(2'd3, 32'd0, 32'hFFFFFFFF, 4'd3);
        chk("t2_mulhu_set0", out_set0, 17'h0FFFE);
        chk("t2_mulhu_inv", out_inv, 17'h00001);

        send_one(2'd2, 32'h80000000, 32'd1, 4'd4);
        chk("t3_mulhsu_mult1", out_multiplier1, 34'h380000000);
        send_one(2'd3, 32'h80000000, 32'd1, 4'd5);
        chk("t3_mulhu_mult1", out_multiplier1, 34'h080000000);
        send_one(2'd0, 32'd0, 32'd3, 4'd6);
        chk("t3_x2_low", out_x2[1:0], 2'b00);
        chk("t3_inv0", out_inv[0], 1);
        chk("t3_set0_1", out_set0[1], 0);
        idle(3);

        // Back-to-back 8 ops with a 3-cycle downstream stall
        out_ready = 1'b0;
        in_valid = 1'b1; drive_rand(4'd0);
        sent = 0; drained = 0; cyc = 0;
        while ((sent < 8 || drained < 8) && cyc < 200) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (cyc == 2) chk("t4_in_ready_drop", in_ready, 0);
            if (out_ready && drained < 8) begin
                chk("t4_no_gap", out_valid, 1);
                if (out_valid) drained++;
            end
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
            out_ready = (cyc >= 3);
            if (sent < 8) drive_rand(4'(sent));
            else in_valid = 1'b0;
        end
        chk("t4_all_drained", drained, 8);
        idle(3);

        // Flush with both entries full and a concurrent offer
        out_ready = 1'b0;
        in_valid = 1'b1; drive_rand(4'd9);
        @(posedge clk); #1;
        drive_rand(4'd10);
        @(posedge clk); #1;
        drive_rand(4'd11);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_in_ready", in_ready, 1);
        send_one(2'd0, 32'd7, 32'd9, 4'd12);
        chk("t5_next_tag", out_tag, 4'd12);
        idle(3);

        // Async reset in the middle of a stall
        out_ready = 1'b0;
        in_valid = 1'b1; drive_rand(4'd13);
        @(posedge clk); #1;
        drive_rand(4'd14);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_mult1", out_multiplier1, 0);
        chk("t6_set0", out_set0, 0);
        chk("t6_inv", out_inv, 0);
        chk("t6_tag", out_tag, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        send_one(2'd0, 32'd3, 32'd5, 4'd15);
        chk("t6_post_set0", out_set0, 17'h1FFFC);
        chk("t6_post_tag", out_tag, 4'd15);
        idle(3);

        // Random traffic
        for (int n = 0; n < 12000; n++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            drive_rand(4'($urandom));
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
